// File: rtl/sipo_deframer_pkg.sv
// Shared constants for the serial deframer: FSM state encodings and line idle level.
package sipo_deframer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STOP  = 2'd2;

  localparam logic SIPO_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_out_hold.sv
// Valid/ready holding register for assembled words; the held word wins over a
// new one when downstream stalls, and the dropped word is flagged as overrun.
module sipo_out_hold
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             overrun
);

  logic [WIDTH-1:0] r_q;
  logic             r_valid;
  logic             r_overrun;
  logic             w_xfer;

  assign w_xfer = r_valid & ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (load) begin
        // a slot frees up either when empty or when it drains this same cycle
        if (!r_valid || w_xfer) begin
          r_q     <= din;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign q       = r_q;
  assign q_valid = r_valid;
  assign overrun = r_overrun;

endmodule

// File: rtl/sipo_deframer.sv
// Start/stop framed serial-to-parallel converter feeding a valid/ready word holder.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a start bit (sin=0)
//   ST_SHIFT | collecting WIDTH data bits
//   ST_STOP  | sampling stop bit; 1 delivers the word, 0 flags frame_err
module sipo_deframer
  import sipo_deframer_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sin,
  input  logic             sin_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             frame_err,
  output logic             overrun
);

  localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_sreg;
  logic             r_frame_err;
  logic [WIDTH-1:0] w_sreg_next;
  logic             w_load;

  generate
    if (MSB_FIRST) begin : g_msb
      assign w_sreg_next = {r_sreg[WIDTH-2:0], sin};
    end else begin : g_lsb
      assign w_sreg_next = {sin, r_sreg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_sreg      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (sin_en) begin
        case (r_state)
          ST_IDLE: begin
            if (sin != SIPO_IDLE_LEVEL) begin
              r_state <= ST_SHIFT;
              r_cnt   <= '0;
            end
          end
          ST_SHIFT: begin
            r_sreg <= w_sreg_next;
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_STOP;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_STOP: begin
            r_frame_err <= ~sin;
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign w_load = sin_en & (r_state == ST_STOP) & sin;

  sipo_out_hold #(.WIDTH(WIDTH)) u_out_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_load),
    .din     (r_sreg),
    .ready   (out_ready),
    .q       (q),
    .q_valid (q_valid),
    .overrun (overrun)
  );

  assign frame_err = r_frame_err;

endmodule
